// File: rtl/lpif_lpbk_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lpif_lpbk_chk_pkg
// Purpose  : Shared types, constants and PRBS helpers for the LPIF AIB
//            loopback generator/checker.
// Revision : 1.0 - initial release
// ============================================================================
package lpif_lpbk_chk_pkg;

   // Test sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
   localparam logic [31:0] c_lfsr_mask = 32'h8020_0003;

   // Golden-ratio constant used to decorrelate the 32-bit chunks of a word
   localparam logic [31:0] c_golden    = 32'h9E37_79B9;

   // One Galois LFSR step
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? c_lfsr_mask : 32'h0);
   endfunction

   // Chunk k of the expanded word for LFSR state s; chunk 0 is the LSB chunk
   function automatic logic [31:0] gen_word(input logic [31:0] s, input logic [31:0] k);
      return s ^ (c_golden * k);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lpif_lpbk_chk_prbs_gen.sv
`default_nettype none
// ============================================================================
// Module   : lpif_prbs_gen
// Purpose  : 32-bit Galois LFSR with expansion to a W-bit data word.
//            o_word is the word for the state consumed this cycle: the load
//            value when i_load is high, otherwise the held LFSR state.
//            Loading or advancing leaves the successor of that state.
// Revision : 1.0 - initial release
// ============================================================================
module lpif_prbs_gen
   import lpif_lpbk_chk_pkg::*;
#(
   parameter int W = 320
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [31:0]  i_seed,
   input  logic         i_adv,
   output logic [W-1:0] o_word
);

   localparam int c_nch = (W + 31) / 32;

   logic [31:0]         lfsr_q;
   logic [31:0]         lfsr_d;
   logic [31:0]         w_src;
   logic [c_nch*32-1:0] w_full;

   assign w_src = i_load ? i_seed : lfsr_q;

   // Step past the state being consumed whenever the stream moves
   always_comb begin
      lfsr_d = lfsr_q;
      if (i_load || i_adv) begin
         lfsr_d = lfsr_next(w_src);
      end
   end

   // LFSR state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= 32'h0000_0001;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   generate
      for (genvar k = 0; k < c_nch; k++) begin : g_chunk
         assign w_full[k*32 +: 32] = gen_word(w_src, 32'(k));
      end
   endgenerate

   assign o_word = w_full[W-1:0];

endmodule
`default_nettype wire

// File: rtl/lpif_lpbk_chk.sv
`default_nettype none
// ============================================================================
// Module   : lpif_lpbk_chk
// Purpose  : Far-end AIB loopback pattern generator and checker. Sends a PRBS
//            word stream on dout_gen, aligns to the looped stream on
//            data_in_f within LAT_MAX cycles, then compares num_words words.
// Options  : LPIF_LPBK_CHK_ERR_INJ_EN adds input err_inj; a pulse in CHECK
//            inverts bit 0 of the next transmitted word.
// Revision : 1.0 - initial release
// ============================================================================
module lpif_lpbk_chk
   import lpif_lpbk_chk_pkg::*;
#(
   parameter int          AIB_LANES         = 4,
   parameter int          AIB_BITS_PER_LANE = 80,
   parameter logic [31:0] SEED              = 32'h0000_0001,
   parameter int          LAT_MAX           = 64,
   parameter int          CNT_W             = 16
)
(
   input  logic                                   lclk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [CNT_W-1:0]                       num_words,
`ifdef LPIF_LPBK_CHK_ERR_INJ_EN
   input  logic                                   err_inj,
`endif
   output logic [AIB_LANES*AIB_BITS_PER_LANE-1:0] dout_gen,
   input  logic [AIB_LANES*AIB_BITS_PER_LANE-1:0] data_in_f,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   pass,
   output logic                                   timeout,
   output logic [CNT_W-1:0]                       err_cnt
);

   localparam int          W      = AIB_LANES * AIB_BITS_PER_LANE;
   localparam int          LW     = $clog2(LAT_MAX + 1);
   localparam logic [31:0] c_seed = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [LW-1:0]    lat_q, lat_d;
   logic             timeout_q, timeout_d;
   logic [W-1:0]     dout_q, dout_d;

   logic             w_start_acc;
   logic             w_tx_run;
   logic             w_in_send;
   logic             w_in_check;
   logic [W-1:0]     w_tx_word;
   logic [W-1:0]     w_rx_word;
   logic             w_match;

   assign w_in_send   = (state_q == SEND);
   assign w_in_check  = (state_q == CHECK);
   assign w_tx_run    = w_in_send || w_in_check;
   assign w_start_acc = start && ((state_q == IDLE) || (state_q == DONE));
   assign w_match     = (data_in_f == w_rx_word);

   // Transmit stream: seeded on an accepted start, free-running while busy
   lpif_prbs_gen #(.W(W)) u_tx_gen (
      .clk    (lclk),
      .rst    (rst),
      .i_load (w_start_acc),
      .i_seed (c_seed),
      .i_adv  (w_tx_run),
      .o_word (w_tx_word)
   );

   // Receive reference: pinned to the seed while aligning, steps in CHECK
   lpif_prbs_gen #(.W(W)) u_rx_gen (
      .clk    (lclk),
      .rst    (rst),
      .i_load (w_in_send),
      .i_seed (c_seed),
      .i_adv  (w_in_check),
      .o_word (w_rx_word)
   );

   // Sequencer next-state, counters and next transmit word
   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      lat_d     = lat_q;
      timeout_d = timeout_q;

      case (state_q)
         IDLE, DONE: begin
            if (w_start_acc) begin
               state_d   = SEND;
               num_d     = (num_words == '0) ? CNT_W'(1) : num_words;
               cnt_d     = '0;
               err_d     = '0;
               lat_d     = '0;
               timeout_d = 1'b0;
            end
         end
         SEND: begin
            // A match on the last allowed cycle still aligns
            if (w_match) begin
               cnt_d   = CNT_W'(1);
               state_d = (num_q == CNT_W'(1)) ? DONE : CHECK;
            end else if (lat_q == LW'(LAT_MAX - 1)) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               lat_d = lat_q + LW'(1);
            end
         end
         CHECK: begin
            if (!w_match && (err_q != '1)) begin
               err_d = err_q + CNT_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == num_q) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The word launched next tracks the state we are entering
      dout_d = ((state_d == SEND) || (state_d == CHECK)) ? w_tx_word : '0;
`ifdef LPIF_LPBK_CHK_ERR_INJ_EN
      if (err_inj && w_in_check && (state_d == CHECK)) begin
         dout_d[0] = ~dout_d[0];
      end
`endif
   end

   // Sequencer and output registers; reset aborts any test in flight
   always_ff @(posedge lclk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         num_q     <= '0;
         cnt_q     <= '0;
         err_q     <= '0;
         lat_q     <= '0;
         timeout_q <= 1'b0;
         dout_q    <= '0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         lat_q     <= lat_d;
         timeout_q <= timeout_d;
         dout_q    <= dout_d;
      end
   end

   assign dout_gen = dout_q;
   assign busy     = w_tx_run;
   assign done     = (state_q == DONE);
   assign timeout  = timeout_q;
   assign err_cnt  = err_q;
   assign pass     = done && !timeout_q && (err_q == '0);

endmodule
`default_nettype wire
